// File: rtl/blake_pkg.sv
// Shared BLAKE-512 constants, state encoding and helpers for the loader and datapath.
package blake_pkg;

  localparam int unsigned WWIDTH        = 64;
  localparam int unsigned MSG_WORDS_DEF = 10;
  localparam int unsigned BLK_WORDS     = 16;
  localparam int unsigned PAD_LO_IDX    = 13;
  localparam int unsigned LEN_IDX       = 15;

  localparam logic [63:0] PAD_ONE_HI = 64'h8000_0000_0000_0000;
  localparam logic [63:0] PAD_ONE_LO = 64'h0000_0000_0000_0001;

  // Chaining-value initialisation for BLAKE-512
  localparam logic [7:0][63:0] IV512 = {
    64'h5BE0CD19137E2179, 64'h1F83D9ABFB41BD6B,
    64'h9B05688C2B3E6C1F, 64'h510E527FADE682D1,
    64'hA54FF53A5F1D36F1, 64'h3C6EF372FE94F82B,
    64'hBB67AE8584CAA73B, 64'h6A09E667F3BCC908
  };

  // Round constants (digits of pi), index 0 in the low slot
  localparam logic [15:0][63:0] CB = {
    64'h636920D871574E69, 64'h0801F2E2858EFC16,
    64'h24A19947B3916CF7, 64'hBA7C9045F12C7F99,
    64'hB8E1AFED6A267E96, 64'h2FFD72DBD01ADFB7,
    64'hD1310BA698DFB5AC, 64'h9216D5D98979FB1B,
    64'h3F84D5B5B5470917, 64'hC0AC29B7C97C50DD,
    64'hBE5466CF34E90C6C, 64'h452821E638D01377,
    64'h082EFA98EC4E6C89, 64'hA4093822299F31D0,
    64'h13198A2E03707344, 64'h243F6A8885A308D3
  };

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } pad_state_e;

  function automatic logic [63:0] msg_len_bits(input int unsigned n_words);
    return 64'(n_words) * 64'(WWIDTH);
  endfunction

endpackage

// File: rtl/blake_word_swap.sv
// Combinational 64-bit byte reverser for little-endian word sources.
module blake_word_swap (
  input  logic [63:0] din,
  output logic [63:0] dout_c
);

  for (genvar b = 0; b < 8; b++) begin : g_byte
    assign dout_c[b*8 +: 8] = din[(7-b)*8 +: 8];
  end

endmodule

// File: rtl/blake_msg_padder.sv
// Assembles MSG_WORDS 64-bit words into one padded BLAKE-512 block.
// BLAKE_LE_INPUT_EN: byte-reverse every incoming message word before storage.
module blake_msg_padder #(
  parameter int unsigned WWIDTH    = 64,
  parameter int unsigned MSG_WORDS = blake_pkg::MSG_WORDS_DEF
) (
  input  logic                                    clk,
  input  logic                                    rstb,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic [WWIDTH-1:0]                       s_data,
  input  logic                                    s_last,
  output logic                                    blk_valid,
  input  logic                                    blk_ready,
  output logic [blake_pkg::BLK_WORDS*WWIDTH-1:0]  padded_block,
  output logic                                    frame_err
);

  import blake_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(MSG_WORDS - 1);

  pad_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_d;
  logic              accept;
  logic              wr_en;
  logic              finish;
  logic [WWIDTH-1:0] word_in;

`ifdef BLAKE_LE_INPUT_EN
  blake_word_swap u_swap (
    .din    (s_data),
    .dout_c (word_in)
  );
`else
  assign word_in = s_data;
`endif

  function automatic logic [WWIDTH-1:0] pad_word(input int unsigned idx);
    if (idx == MSG_WORDS)       return PAD_ONE_HI;
    else if (idx == PAD_LO_IDX) return PAD_ONE_LO;
    else if (idx == LEN_IDX)    return msg_len_bits(MSG_WORDS);
    else                        return '0;
  endfunction

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      frame_err <= 1'b0;
      s_ready   <= 1'b0;
      blk_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_err <= err_d;
      s_ready   <= (state_d == FILL);
      blk_valid <= (state_d == OUT);
    end
  end

  // Framing: early s_last drops the partial frame; missing s_last still emits the block
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = frame_err;
    accept  = s_valid & s_ready;
    wr_en   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (cnt_q == LAST_IDX) begin
            wr_en   = 1'b1;
            finish  = 1'b1;
            state_d = OUT;
            cnt_d   = '0;
            if (!s_last) err_d = 1'b1;
          end else if (s_last) begin
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            cnt_d = 4'(cnt_q + 4'd1);
          end
        end
      end
      OUT: begin
        if (blk_valid && blk_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Block register file: message words at cnt, padding words on the closing edge
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      padded_block <= '0;
    end else begin
      for (int unsigned i = 0; i < BLK_WORDS; i++) begin
        if (i < MSG_WORDS) begin
          if (wr_en && (cnt_q == 4'(i)))
            padded_block[(BLK_WORDS-1-i)*WWIDTH +: WWIDTH] <= word_in;
        end else if (finish) begin
          padded_block[(BLK_WORDS-1-i)*WWIDTH +: WWIDTH] <= pad_word(i);
        end
      end
    end
  end

endmodule

// File: tb/tb_blake_msg_padder.sv
// Directed self-checking bench for blake_msg_padder (default MSG_WORDS=10).
module tb_blake_msg_padder;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [63:0]   s_data = '0;
  logic          s_last = 1'b0;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic [1023:0] padded_block;
  logic          frame_err;

  int n_asserts = 0;
  int n_fail    = 0;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        exp_blk_valid;
    logic        exp_s_ready;
  } in_vec_t;

  typedef struct {
    int          idx;
    logic [63:0] exp;
  } pad_vec_t;

  in_vec_t  frame_tbl[10];
  pad_vec_t pad_tbl[6];

  blake_msg_padder dut (
    .clk          (clk),
    .rstb         (rstb),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .padded_block (padded_block),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] blk_word(input int i);
    return padded_block[(15-i)*64 +: 64];
  endfunction

  // Expected stored form of a message word
  function automatic logic [63:0] stored(input logic [63:0] d);
`ifdef BLAKE_LE_INPUT_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40], d[55:48], d[63:56]};
`else
    return d;
`endif
  endfunction

  // Called at a negedge; returns at the negedge after the word was accepted
  task automatic send_word(input logic [63:0] d, input logic l);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) chk("send_timeout", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] base, input int n, input int last_at);
    for (int i = 0; i < n; i++) send_word(base + 64'(i), i == last_at);
  endtask

  task automatic check_block(input string nm, input logic [63:0] base);
    chk({nm, "_blk_valid"}, 64'(blk_valid), 64'd1);
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s_w%0d", nm, i), blk_word(i), stored(base + 64'(i)));
    for (int k = 0; k < 6; k++)
      chk($sformatf("%s_w%0d", nm, pad_tbl[k].idx), blk_word(pad_tbl[k].idx), pad_tbl[k].exp);
  endtask

  task automatic take_block(input string nm);
    int t = 0;
    while (!blk_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_wait_blk"}, 64'(blk_valid), 64'd1);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    chk({nm, "_s_ready_after"}, 64'(s_ready), 64'd1);
    chk({nm, "_blk_valid_after"}, 64'(blk_valid), 64'd0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({nm, "_blk_valid"}, 64'(blk_valid), 64'd0);
    chk({nm, "_frame_err"}, 64'(frame_err), 64'd0);
    chk({nm, "_block_zero"}, 64'(padded_block == '0), 64'd1);
  endtask

  initial begin
    logic [1023:0] snap;

    for (int i = 0; i < 10; i++)
      frame_tbl[i] = '{data: 64'(i), last: (i == 9), exp_blk_valid: (i == 9), exp_s_ready: (i != 9)};
    pad_tbl[0] = '{idx: 10, exp: 64'h8000_0000_0000_0000};
    pad_tbl[1] = '{idx: 11, exp: 64'h0};
    pad_tbl[2] = '{idx: 12, exp: 64'h0};
    pad_tbl[3] = '{idx: 13, exp: 64'h0000_0000_0000_0001};
    pad_tbl[4] = '{idx: 14, exp: 64'h0};
    pad_tbl[5] = '{idx: 15, exp: 64'h280};

    // Reset values and first ready
    #12;
    chk_reset("rst");
    @(negedge clk);
    rstb = 1'b1;
    chk("rst_release_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    chk("first_edge_s_ready", 64'(s_ready), 64'd1);

    // 1: clean 10-word frame from the vector table
    for (int i = 0; i < 10; i++) begin
      send_word(frame_tbl[i].data, frame_tbl[i].last);
      chk($sformatf("t1_blk_valid_%0d", i), 64'(blk_valid), 64'(frame_tbl[i].exp_blk_valid));
      chk($sformatf("t1_s_ready_%0d", i), 64'(s_ready), 64'(frame_tbl[i].exp_s_ready));
    end
    check_block("t1", 64'h0);
    chk("t1_frame_err", 64'(frame_err), 64'd0);

    // 2: hold with back-pressure, then single-cycle consume
    snap      = padded_block;
    s_valid   = 1'b1;
    s_data    = 64'hDEAD_BEEF_0000_0000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("t2_s_ready_%0d", c), 64'(s_ready), 64'd0);
      chk($sformatf("t2_hold_%0d", c), 64'(padded_block == snap), 64'd1);
    end
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    s_valid   = 1'b0;
    chk("t2_s_ready_after", 64'(s_ready), 64'd1);
    chk("t2_blk_valid_after", 64'(blk_valid), 64'd0);

    // 4: late end (no s_last) still emits a padded block and flags an error
    send_frame(64'h20, 10, -1);
    check_block("t4", 64'h20);
    chk("t4_frame_err", 64'(frame_err), 64'd1);
    take_block("t4");

    // 5: reset mid-frame clears everything, then a fresh frame works
    send_frame(64'h30, 6, -1);
    chk("t5_no_blk", 64'(blk_valid), 64'd0);
    rstb = 1'b0;
    #1;
    chk_reset("t5_rst");
    @(negedge clk);
    rstb = 1'b1;
    chk("t5_release_s_ready", 64'(s_ready), 64'd0);
    send_frame(64'h400, 10, 9);
    check_block("t5", 64'h400);
    chk("t5_frame_err", 64'(frame_err), 64'd0);
    take_block("t5");

    // 3: early end drops the partial frame; next frame is clean and error stays sticky
    send_frame(64'h10, 4, 3);
    chk("t3_early_err", 64'(frame_err), 64'd1);
    chk("t3_early_no_blk", 64'(blk_valid), 64'd0);
    repeat (3) @(negedge clk);
    chk("t3_still_no_blk", 64'(blk_valid), 64'd0);
    chk("t3_s_ready", 64'(s_ready), 64'd1);
    send_frame(64'h300, 9, -1);
    chk("t3_9words_no_blk", 64'(blk_valid), 64'd0);
    send_word(64'h309, 1'b1);
    check_block("t3", 64'h300);
    chk("t3_err_sticky", 64'(frame_err), 64'd1);
    take_block("t3");

    // 6: byte order of word 0 (swapped only when little-endian input is enabled)
    send_word(64'h0102030405060708, 1'b0);
    for (int i = 1; i < 10; i++) send_word(64'h200 + 64'(i), i == 9);
`ifdef BLAKE_LE_INPUT_EN
    chk("t6_w0", blk_word(0), 64'h0807060504030201);
`else
    chk("t6_w0", blk_word(0), 64'h0102030405060708);
`endif
    chk("t6_w1", blk_word(1), stored(64'h201));
    chk("t6_w10", blk_word(10), 64'h8000_0000_0000_0000);
    chk("t6_w15", blk_word(15), 64'h280);
    take_block("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
